// File: rtl/ibex_defines.sv
// Shared types for the instruction-bus arbiter: master identifiers and a
// helper that returns the opposite master for round-robin rotation.
package ibex_defines;

  typedef enum logic {
    ARB_M_FETCH = 1'b0,
    ARB_M_AUX   = 1'b1
  } arb_master_e;

  function automatic arb_master_e arb_other(input arb_master_e m);
    return (m == ARB_M_FETCH) ? ARB_M_AUX : ARB_M_FETCH;
  endfunction

endpackage

// File: rtl/ibex_arb_owner_fifo.sv
// In-order owner FIFO: records which master issued each granted request so
// returning rvalids can be routed back in issue order.
module ibex_arb_owner_fifo
  import ibex_defines::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  arb_master_e       data_i,
  input  logic              pop_i,
  output arb_master_e       head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_master_e        mem_q [DEPTH];
  arb_master_e        mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_s, do_pop_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Status flags and head entry.
  always_comb begin
    empty_o = (count_q == {CNT_W{1'b0}});
    full_o  = (count_q == CNT_W'(DEPTH));
    count_o = count_q;
    head_o  = mem_q[rd_ptr_q];
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push_s = push_i & ~full_o;
    do_pop_s  = pop_i & ~empty_o;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ARB_M_FETCH;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory req/gnt/rvalid port
// between the fetch path (master 0) and an auxiliary reader (master 1).
module ibex_instr_bus_arbiter
  import ibex_defines::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o,
  output logic        err_rvalid_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_master_e      sel_s, fifo_head_s;
  arb_master_e      lock_owner_q, lock_owner_d;
  arb_master_e      rr_q, rr_d;
  logic             lock_q, lock_d;
  logic             err_rvalid_q, err_rvalid_d;
  logic             sel_req_s, grant_s, pop_s;
  logic [31:0]      sel_addr_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s, fifo_full_s;

  // Arbitration: a pending lock pins the selection until the grant.
  always_comb begin
    sel_s = rr_q;
    if (lock_q) begin
      sel_s = lock_owner_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel_s = ARB_M_FETCH;
    end else if (m1_req_i && !m0_req_i) begin
      sel_s = ARB_M_AUX;
    end else begin
      sel_s = rr_q;
    end
    case (sel_s)
      ARB_M_FETCH: begin sel_req_s = m0_req_i; sel_addr_s = m0_addr_i; end
      ARB_M_AUX:   begin sel_req_s = m1_req_i; sel_addr_s = m1_addr_i; end
      default:     begin sel_req_s = 1'b0;     sel_addr_s = 32'h0;     end
    endcase
  end

  // Outputs; a full FIFO blocks the request regardless of a same-cycle rvalid.
  always_comb begin
    instr_req_o  = rst_n & sel_req_s & ~fifo_full_s;
    instr_addr_o = instr_req_o ? sel_addr_s : 32'h0;
    grant_s      = instr_req_o & instr_gnt_i;
    m0_gnt_o     = grant_s & (sel_s == ARB_M_FETCH);
    m1_gnt_o     = grant_s & (sel_s == ARB_M_AUX);
    pop_s        = instr_rvalid_i & ~fifo_empty_s;
    m0_rvalid_o  = pop_s & (fifo_head_s == ARB_M_FETCH);
    m1_rvalid_o  = pop_s & (fifo_head_s == ARB_M_AUX);
    m0_rdata_o   = rst_n ? instr_rdata_i : 32'h0;
    m1_rdata_o   = rst_n ? instr_rdata_i : 32'h0;
    busy_o       = instr_req_o | (fifo_count_s != {CNT_W{1'b0}});
    err_rvalid_o = err_rvalid_q;
  end

  // Lock, rotation and error next-state; a dropped request releases the lock.
  always_comb begin
    lock_d       = instr_req_o & ~instr_gnt_i;
    lock_owner_d = lock_owner_q;
    rr_d         = rr_q;
    if (lock_d) begin
      lock_owner_d = sel_s;
    end else begin
      lock_owner_d = lock_owner_q;
    end
    if (grant_s) begin
      rr_d = arb_other(sel_s);
    end else begin
      rr_d = rr_q;
    end
    err_rvalid_d = err_rvalid_q | (instr_rvalid_i & fifo_empty_s);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      lock_owner_q <= ARB_M_FETCH;
      rr_q         <= ARB_M_FETCH;
      err_rvalid_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      rr_q         <= rr_d;
      err_rvalid_q <= err_rvalid_d;
    end
  end

  ibex_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant_s),
    .data_i  (sel_s),
    .pop_i   (pop_s),
    .head_o  (fifo_head_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Scoreboard bench: expected grant owners are queued as stimulus is applied
// and popped to predict rvalid routing when memory returns data.
module tb_ibex_instr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        busy_o, err_rvalid_o;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic err_exp  = 1'b0;

  always #5 clk = ~clk;

  ibex_instr_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m1_req_i       (m1_req_i),
    .m1_addr_i      (m1_addr_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o),
    .err_rvalid_o   (err_rvalid_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check outputs mid-cycle, update the scoreboard.
  task automatic cyc(input string tag,
                     input logic r0, input logic [31:0] a0,
                     input logic r1, input logic [31:0] a1,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic eg0, input logic eg1);
    logic own;
    m0_req_i = r0; m0_addr_i = a0;
    m1_req_i = r1; m1_addr_i = a1;
    instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd;
    #2;
    check_eq({tag, ".req"},  32'(instr_req_o), 32'(ereq));
    check_eq({tag, ".addr"}, instr_addr_o, eaddr);
    check_eq({tag, ".gnt0"}, 32'(m0_gnt_o), 32'(eg0));
    check_eq({tag, ".gnt1"}, 32'(m1_gnt_o), 32'(eg1));
    check_eq({tag, ".busy"}, 32'(busy_o), 32'(ereq | (exp_q.size() != 0)));
    check_eq({tag, ".err"},  32'(err_rvalid_o), 32'(err_exp));
    if (rv && exp_q.size() > 0) begin
      own = exp_q.pop_front();
      check_eq({tag, ".rv0"}, 32'(m0_rvalid_o), 32'(own == 1'b0));
      check_eq({tag, ".rv1"}, 32'(m1_rvalid_o), 32'(own == 1'b1));
      check_eq({tag, ".rdata"}, own ? m1_rdata_o : m0_rdata_o, rd);
    end else begin
      check_eq({tag, ".rv0"}, 32'(m0_rvalid_o), 32'h0);
      check_eq({tag, ".rv1"}, 32'(m1_rvalid_o), 32'h0);
      if (rv) err_exp = 1'b1;
    end
    if (eg0) exp_q.push_back(1'b0);
    if (eg1) exp_q.push_back(1'b1);
    @(posedge clk); #1;
  endtask

  // Asynchronous reset with busy inputs; every output must read zero.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h1234_5678;
    m1_req_i = 1'b1; m1_addr_i = 32'h8765_4321;
    instr_gnt_i = 1'b1; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hA5A5_A5A5;
    #2;
    check_eq({tag, ".req"},  32'(instr_req_o), 32'h0);
    check_eq({tag, ".addr"}, instr_addr_o, 32'h0);
    check_eq({tag, ".gnt"},  32'({m0_gnt_o, m1_gnt_o}), 32'h0);
    check_eq({tag, ".rv"},   32'({m0_rvalid_o, m1_rvalid_o}), 32'h0);
    check_eq({tag, ".rd0"},  m0_rdata_o, 32'h0);
    check_eq({tag, ".rd1"},  m1_rdata_o, 32'h0);
    check_eq({tag, ".busy"}, 32'(busy_o), 32'h0);
    check_eq({tag, ".err"},  32'(err_rvalid_o), 32'h0);
    exp_q.delete();
    err_exp = 1'b0;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req_i = 1'b0; m0_addr_i = 32'h0; m1_req_i = 1'b0; m1_addr_i = 32'h0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    @(posedge clk); #1;
    do_reset("rst0");

    // Solo fetch
    cyc("solo0", 1, 32'h1A00_0080, 0, 32'h0, 1, 0, 32'h0,         1, 32'h1A00_0080, 1, 0);
    cyc("solo1", 0, 32'h0,         0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0, 0);
    cyc("solo2", 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,         0, 32'h0,         0, 0);

    // Contention: alternate m0,m1,m0,m1
    do_reset("rst1");
    cyc("cont0", 1, 32'h1000, 1, 32'h2000, 1, 0, 32'h0,       1, 32'h1000, 1, 0);
    cyc("cont1", 1, 32'h1000, 1, 32'h2000, 1, 1, 32'h1111_0001, 1, 32'h2000, 0, 1);
    cyc("cont2", 1, 32'h1000, 1, 32'h2000, 1, 1, 32'h2222_0002, 1, 32'h1000, 1, 0);
    cyc("cont3", 1, 32'h1000, 1, 32'h2000, 1, 1, 32'h3333_0003, 1, 32'h2000, 0, 1);
    cyc("cont4", 0, 32'h0,    0, 32'h0,    0, 1, 32'h4444_0004, 0, 32'h0,    0, 0);

    // Lock: rr favours m1, but m0's stalled request holds the bus
    do_reset("rst2");
    cyc("lockp0", 1, 32'h40,  0, 32'h0,   1, 0, 32'h0,  1, 32'h40,  1, 0);
    cyc("lockp1", 0, 32'h0,   0, 32'h0,   0, 1, 32'h55, 0, 32'h0,   0, 0);
    cyc("lockA",  1, 32'h100, 0, 32'h0,   0, 0, 32'h0,  1, 32'h100, 0, 0);
    cyc("lockB",  1, 32'h100, 1, 32'h200, 0, 0, 32'h0,  1, 32'h100, 0, 0);
    cyc("lockC",  1, 32'h100, 1, 32'h200, 0, 0, 32'h0,  1, 32'h100, 0, 0);
    cyc("lockD",  1, 32'h100, 1, 32'h200, 1, 0, 32'h0,  1, 32'h100, 1, 0);
    cyc("lockE",  0, 32'h0,   1, 32'h200, 1, 0, 32'h0,  1, 32'h200, 0, 1);
    cyc("lockR0", 0, 32'h0,   0, 32'h0,   0, 1, 32'h66, 0, 32'h0,   0, 0);
    cyc("lockR1", 0, 32'h0,   0, 32'h0,   0, 1, 32'h77, 0, 32'h0,   0, 0);
    // Lock drop: locked m1 withdraws, nothing is issued that cycle
    cyc("dropF",  0, 32'h0,   1, 32'h300, 0, 0, 32'h0,  1, 32'h300, 0, 0);
    cyc("dropG",  1, 32'h400, 0, 32'h0,   1, 0, 32'h0,  0, 32'h0,   0, 0);
    cyc("dropH",  1, 32'h400, 0, 32'h0,   1, 0, 32'h0,  1, 32'h400, 1, 0);
    cyc("dropR",  0, 32'h0,   0, 32'h0,   0, 1, 32'h88, 0, 32'h0,   0, 0);

    // Full: two outstanding blocks a third, even with a same-cycle rvalid
    do_reset("rst3");
    cyc("full0", 1, 32'h10, 0, 32'h0, 1, 0, 32'h0,  1, 32'h10, 1, 0);
    cyc("full1", 1, 32'h14, 0, 32'h0, 1, 0, 32'h0,  1, 32'h14, 1, 0);
    cyc("full2", 1, 32'h18, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
    cyc("full3", 1, 32'h18, 0, 32'h0, 1, 1, 32'hA1, 0, 32'h0,  0, 0);
    cyc("full4", 1, 32'h18, 0, 32'h0, 1, 0, 32'h0,  1, 32'h18, 1, 0);
    cyc("full5", 0, 32'h0,  0, 32'h0, 0, 1, 32'hA2, 0, 32'h0,  0, 0);
    cyc("full6", 0, 32'h0,  0, 32'h0, 0, 1, 32'hA3, 0, 32'h0,  0, 0);

    // Simultaneous push/pop, then an unexpected rvalid sets the sticky error
    do_reset("rst4");
    cyc("sim0", 1, 32'h20, 0, 32'h0,  1, 0, 32'h0,  1, 32'h20, 1, 0);
    cyc("sim1", 0, 32'h0,  1, 32'h24, 1, 1, 32'hB1, 1, 32'h24, 0, 1);
    cyc("sim2", 0, 32'h0,  0, 32'h0,  0, 1, 32'hB2, 0, 32'h0,  0, 0);
    cyc("err0", 0, 32'h0,  0, 32'h0,  0, 1, 32'hB3, 0, 32'h0,  0, 0);
    cyc("err1", 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 32'h0,  0, 0);
    cyc("err2", 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 32'h0,  0, 0);

    // Reset mid-transaction with two outstanding and rr pointing at m1
    cyc("mid0", 0, 32'h0,  1, 32'h30, 1, 0, 32'h0,  1, 32'h30, 0, 1);
    cyc("mid1", 1, 32'h34, 0, 32'h0,  1, 0, 32'h0,  1, 32'h34, 1, 0);
    do_reset("rst5");
    cyc("post0", 1, 32'h38, 1, 32'h3C, 1, 0, 32'h0,  1, 32'h38, 1, 0);
    cyc("post1", 0, 32'h0,  0, 32'h0,  0, 1, 32'hC1, 0, 32'h0,  0, 0);
    cyc("post2", 0, 32'h0,  0, 32'h0,  0, 1, 32'hC2, 0, 32'h0,  0, 0);
    cyc("post3", 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 32'h0,  0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_instr_bus_arbiter.md
Name: ibex_instr_bus_arbiter

Overview:
Two-master arbiter that shares the single instruction-memory port (req/gnt/rvalid protocol) between the core's fetch path (master 0, prefetch buffer) and a secondary requester (master 1, debug/loader/DMA read port). It applies round-robin arbitration, holds a request stable until granted, and tracks outstanding transactions in an in-order owner FIFO. It uses that FIFO to route each rvalid back to the master that issued the request. It sits between the prefetch buffer and the instruction memory/cache.

Parameters:
MAX_OUTSTANDING, 2, max granted-but-not-returned transactions (1..4); owner FIFO depth
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_req_i  in  1  master 0 (fetch) request
m0_addr_i  in  32  master 0 word address
m0_gnt_o  out  1  master 0 grant
m0_rvalid_o  out  1  master 0 read data valid
m0_rdata_o  out  32  master 0 read data
m1_req_i  in  1  master 1 request
m1_addr_i  in  32  master 1 word address
m1_gnt_o  out  1  master 1 grant
m1_rvalid_o  out  1  master 1 read data valid
m1_rdata_o  out  32  master 1 read data
instr_req_o  out  1  memory request
instr_addr_o  out  32  memory address
instr_gnt_i  in  1  memory grant
instr_rvalid_i  in  1  memory read data valid
instr_rdata_i  in  32  memory read data
busy_o  out  1  request pending or transaction outstanding
err_rvalid_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Reset clears the FIFO, count, lock and error flag. The rr pointer resets to master 0. All outputs are 0 during reset.
- Registered state: owner FIFO (MAX_OUTSTANDING x 1 bit, wr/rd pointers, count), lock_q, lock_owner_q, rr_q (master favoured on next contention).
- Arbitration, combinational, same cycle:
  - If lock_q, sel = lock_owner_q.
  - Otherwise, if one master requests, that master is selected.
  - Otherwise, if both request, sel = rr_q.
- Full condition: instr_req_o = selected master's req AND count < MAX_OUTSTANDING. A full FIFO blocks requests even when rvalid arrives that cycle, so there is no rvalid->req combinational path.
- instr_addr_o = selected master's addr. It is 0 when no request is issued.
- mX_gnt_o = instr_gnt_i & instr_req_o & (sel==X). The non-selected master never sees gnt.
- Lock: lock_q sets when instr_req_o=1 and instr_gnt_i=0; lock_owner_q <= sel. Lock clears on the grant cycle. The address must stay stable until granted; the arbiter does not re-arbitrate while locked, even if the other master has priority.
- Lock drop: if a locked master drops req (protocol violation), the lock clears next cycle and no grant is issued.
- On grant: push sel into the FIFO and set rr_q <= ~sel. rr_q updates only on a grant.
- On instr_rvalid_i with count>0: pop head. m[head]_rvalid_o=1 in the same cycle; the other master's rvalid stays 0.
- On instr_rvalid_i with count==0: no pop, no mX_rvalid_o, err_rvalid_o set (sticky until reset).
- Grant and rvalid in the same cycle: push and pop both happen and count is unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- mX_rdata_o = instr_rdata_i (broadcast); it is only meaningful with mX_rvalid_o.
- Latency: zero added cycles. Request/grant and rvalid are combinational pass-throughs.
- busy_o = instr_req_o | (count != 0).

Decomposition:
- Shared package ibex_defines: add typedef enum logic {ARB_M_FETCH=1'b0, ARB_M_AUX=1'b1} arb_master_e. Use it for sel, lock_owner_q and FIFO entries.
- One sub-module, ibex_arb_owner_fifo: parameterised depth, 1-bit data, push/pop/count/empty/full, async active-low reset.
- Arbitration, lock and routing stay in the top module.

Test Plan:
- Solo fetch: m0_req with addr 0x1A000080, gnt the same cycle, rvalid next cycle with rdata 0xDEADBEEF -> m0_gnt=1 in cycle 0, then m0_rvalid=1 with m0_rdata=0xDEADBEEF, m1_rvalid=0, busy back to 0.
- Contention: both request continuously, gnt every cycle, rr reset to 0 -> grants alternate m0,m1,m0,m1. rvalids return m0,m1,m0,m1 in order.
- Lock: m0 requests at 0x100 with gnt held low 3 cycles while m1 requests with priority -> instr_addr stays 0x100 for all 4 cycles, m0 is granted first, m1 granted next cycle.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid -> instr_req_o=0 on the third request. One rvalid -> request reissued next cycle. A same-cycle rvalid with full FIFO does not grant.
- Simultaneous push/pop: count=1, gnt to m1 and rvalid in the same cycle -> the head's master gets rvalid and count stays 1. The next rvalid routes to m1.
- Errors and reset: rvalid with count=0 -> no mX_rvalid and err_rvalid_o=1 sticky. Assert rst_n mid-transaction with count=2 -> count 0, err cleared, rr=0, and a fresh rvalid after reset sets err.
